// File: rtl/dm_responder.sv
// Data-memory responder for the multi-cycle CPU memory port.
// Accepts one word load/store at a time over valid/ready, waits LATENCY
// cycles, then commits the access and presents a response that is held
// until the CPU consumes it. Misaligned or out-of-range addresses produce
// an errored response, and the first offending address/PC is captured.
module dm_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic [31:0] err_pc
);

    localparam int          ADDR_BITS  = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            pc_q;
    logic                   req_ready_q;
    logic                   resp_valid_q;
    logic [31:0]            resp_rdata_q;
    logic                   resp_err_q;
    logic                   err_flag_q;
    logic [31:0]            err_addr_q;
    logic [31:0]            err_pc_q;

    // Storage is left unreset; a per-word "written" bit makes every word
    // read back as zero after reset without having to clear the array.
    logic [DEPTH-1:0]       written_q;
    logic [31:0]            mem_q [DEPTH];

    logic                   accept;
    logic                   commit;
    logic                   c_we;
    logic [31:0]            c_addr;
    logic [31:0]            c_wdata;
    logic [31:0]            c_pc;
    logic                   c_err;
    logic [ADDR_BITS-1:0]   c_idx;
    logic [31:0]            c_rdata;

    // Select the request being committed: straight from the port when there
    // are no wait states, otherwise from the copy latched at accept.
    always_comb begin
        accept  = (state_q == IDLE) && req_valid;
        commit  = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 4'd1));
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_pc    = pc_q;
        if (state_q == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_pc    = req_pc;
        end
        c_err   = (c_addr[1:0] != 2'b00) || ({1'b0, c_addr} >= ADDR_LIMIT);
        c_idx   = c_addr[ADDR_BITS+1:2];
        c_rdata = written_q[c_idx] ? mem_q[c_idx] : 32'h0;
    end

    // Word storage: a good store is written on the commit edge, never while reset is held.
    always_ff @(posedge clk) begin
        if (reset && commit && c_we && !c_err) begin
            mem_q[c_idx] <= c_wdata;
        end
    end

    // Request FSM with registered handshake, response and error-capture outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            pc_q         <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            err_flag_q   <= 1'b0;
            err_addr_q   <= 32'h0;
            err_pc_q     <= 32'h0;
            written_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        pc_q        <= req_pc;
                        cnt_q       <= 4'(LATENCY);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase

            if (commit) begin
                state_q      <= RESP;
                resp_valid_q <= 1'b1;
                resp_err_q   <= c_err;
                resp_rdata_q <= (c_we || c_err) ? 32'h0 : c_rdata;
                if (c_we && !c_err) begin
                    written_q[c_idx] <= 1'b1;
                end
                if (c_err && !err_flag_q) begin
                    err_flag_q <= 1'b1;
                    err_addr_q <= c_addr;
                    err_pc_q   <= c_pc;
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign err_flag   = err_flag_q;
    assign err_addr   = err_addr_q;
    assign err_pc     = err_pc_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: two instances (LATENCY=2 and LATENCY=0) share the
// clock and reset and are checked against a word-array reference model.
module tb_dm_responder;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        reqValid   [2];
    logic        reqReady   [2];
    logic        reqWe      [2];
    logic [31:0] reqAddr    [2];
    logic [31:0] reqWdata   [2];
    logic [31:0] reqPc      [2];
    logic        respValid  [2];
    logic        respReady  [2];
    logic [31:0] respRdata  [2];
    logic        respErr    [2];
    logic        errFlag    [2];
    logic [31:0] errAddr    [2];
    logic [31:0] errPc      [2];

    int          latOf [2] = '{2, 0};

    int unsigned modelMem     [2][DEPTH];
    bit          modelErrFlag [2];
    logic [31:0] modelErrAddr [2];
    logic [31:0] modelErrPc   [2];

    int checks = 0;
    int errors = 0;

    dm_responder #(.DEPTH(DEPTH), .LATENCY(2)) uDut2 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_pc(reqPc[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0]),
        .err_flag(errFlag[0]), .err_addr(errAddr[0]), .err_pc(errPc[0])
    );

    dm_responder #(.DEPTH(DEPTH), .LATENCY(0)) uDut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_pc(reqPc[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1]),
        .err_flag(errFlag[1]), .err_addr(errAddr[1]), .err_pc(errPc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) modelMem[d][i] = 0;
            modelErrFlag[d] = 1'b0;
            modelErrAddr[d] = 32'h0;
            modelErrPc[d]   = 32'h0;
        end
    endtask

    // Reference behaviour of one completed access, in plain arithmetic.
    task automatic modelTxn(input int d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] pc,
                            output logic [31:0] expRdata, output bit expErr);
        longint unsigned a;
        a        = longint'(addr);
        expErr   = (a % 4 != 0) || (a >= 4 * DEPTH);
        expRdata = 32'h0;
        if (expErr) begin
            if (!modelErrFlag[d]) begin
                modelErrFlag[d] = 1'b1;
                modelErrAddr[d] = addr;
                modelErrPc[d]   = pc;
            end
        end else if (we) begin
            modelMem[d][a / 4] = wdata;
        end else begin
            expRdata = modelMem[d][a / 4];
        end
    endtask

    // One full request/response exchange on instance d, holding resp_ready low
    // for holdCycles cycles while poking a competing request.
    task automatic applyStimulus(input int d, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] pc,
                                 input int holdCycles);
        logic [31:0] expRdata;
        bit          expErr;
        int          n;
        n = 0;
        while (!reqReady[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reqReadyBeforeAccept", 32'(reqReady[d]), 32'd1);
        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        reqPc[d]    = pc;
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0;
        reqWe[d]    = 1'($urandom);
        reqAddr[d]  = $urandom;
        reqWdata[d] = $urandom;
        reqPc[d]    = $urandom;
        modelTxn(d, we, addr, wdata, pc, expRdata, expErr);
        n = 0;
        while (!respValid[d] && n < 40) begin
            checkOutput("reqReadyInWait", 32'(reqReady[d]), 32'd0);
            @(negedge clk);
            n++;
        end
        checkOutput("respLatency", 32'(n), 32'(latOf[d]));
        checkOutput("respValid", 32'(respValid[d]), 32'd1);
        checkOutput("respRdata", respRdata[d], expRdata);
        checkOutput("respErr", 32'(respErr[d]), 32'(expErr));
        for (int h = 0; h < holdCycles; h++) begin
            reqValid[d] = 1'b1;
            reqAddr[d]  = $urandom;
            reqWdata[d] = $urandom;
            @(negedge clk);
            checkOutput("holdValid", 32'(respValid[d]), 32'd1);
            checkOutput("holdRdata", respRdata[d], expRdata);
            checkOutput("holdErr", 32'(respErr[d]), 32'(expErr));
            checkOutput("holdReqReady", 32'(reqReady[d]), 32'd0);
        end
        reqValid[d]  = 1'b0;
        respReady[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        respReady[d] = 1'b0;
        checkOutput("postValid", 32'(respValid[d]), 32'd0);
        checkOutput("postRdata", respRdata[d], 32'h0);
        checkOutput("postErr", 32'(respErr[d]), 32'd0);
        checkOutput("postReqReady", 32'(reqReady[d]), 32'd1);
        checkOutput("errFlag", 32'(errFlag[d]), 32'(modelErrFlag[d]));
        checkOutput("errAddr", errAddr[d], modelErrAddr[d]);
        checkOutput("errPc", errPc[d], modelErrPc[d]);
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = 32'($urandom_range(0, 15)) * 4;
            3:       a = 32'($urandom_range(1000, 1023)) * 4;
            4:       a = (32'($urandom_range(0, 4095)) & ~32'h3) | 32'($urandom_range(1, 3));
            default: a = ($urandom_range(0, 1) == 0) ? 32'h1000 + ($urandom & 32'h0FFF_FFFC) : 32'hFFFF_FFFC;
        endcase
        return a;
    endfunction

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            reqValid[d]  = 1'b0;
            reqWe[d]     = 1'b0;
            reqAddr[d]   = 32'h0;
            reqWdata[d]  = 32'h0;
            reqPc[d]     = 32'h0;
            respReady[d] = 1'b0;
        end
        clearModel();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rstReqReady", 32'(reqReady[d]), 32'd1);
            checkOutput("rstRespValid", 32'(respValid[d]), 32'd0);
            checkOutput("rstErrFlag", 32'(errFlag[d]), 32'd0);
            checkOutput("rstErrAddr", errAddr[d], 32'h0);
            checkOutput("rstRdata", respRdata[d], 32'h0);
        end

        // Directed cases on both latencies
        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b0, 32'h0,    32'h0,        32'h1000, 0);
            applyStimulus(d, 1'b1, 32'h10,   32'hDEADBEEF, 32'h1004, 0);
            applyStimulus(d, 1'b0, 32'h10,   32'h0,        32'h1008, 0);
            applyStimulus(d, 1'b1, 32'h6,    32'h12345678, 32'h3004, 0);
            applyStimulus(d, 1'b0, 32'h4,    32'h0,        32'h3008, 0);
            applyStimulus(d, 1'b1, 32'h1000, 32'h55555555, 32'h300C, 0);
            applyStimulus(d, 1'b0, 32'h1000, 32'h0,        32'h3010, 0);
            applyStimulus(d, 1'b1, 32'hFFC,  32'hCAFEF00D, 32'h3014, 1);
            applyStimulus(d, 1'b0, 32'hFFC,  32'h0,        32'h3018, 5);
        end

        // Randomized traffic on both instances
        for (int i = 0; i < 120; i++) begin
            applyStimulus(i % 2, 1'($urandom), randAddr(), $urandom, $urandom,
                          int'($urandom_range(0, 3)));
        end

        // Reset during WAIT drops a pending store
        reqValid[0] = 1'b1;
        reqWe[0]    = 1'b1;
        reqAddr[0]  = 32'h20;
        reqWdata[0] = 32'hA5A5A5A5;
        reqPc[0]    = 32'h4000;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        reset       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clearModel();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("noSpuriousValid", 32'(respValid[0]), 32'd0);
        end
        checkOutput("rstErrFlagAgain", 32'(errFlag[0]), 32'd0);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 32'h4004, 0);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 32'h4008, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
